arbiter_puf: RTL and testbench
==============================

// Module: arbiter_puf
// PURPOSE
//  Deterministic, synthesizable model of an 8-bit arbiter PUF: 8 independent 64-stage switch chains
//  evaluate a 64-bit challenge serially, one stage per clock, and produce one response bit each.
//  Sits between the board controller (start/challenge) and the LED/7-segment readout.
//  Also drives one active-low 7-segment digit per response bit.
// PARAMETERS
//  N_STAGES  64       switch stages per chain; equals challenge width
//  N_CHAINS  8        chains; equals response width
//  SEED      16'hACE1 base LFSR seed for the stage-delay mismatch weights
// PORTS
//  CLOCK_50   in   1   sole clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  signal     in   1   start request, sampled in IDLE only
//  challenge  in   64  challenge word, captured on accepted start
//  response   out  8   response byte, held until next completion or reset
//  valid      out  1   one-cycle pulse when response updates
//  busy       out  1   high while in RUN
//  HEX0..HEX7 out  7   each; active-low segments {g,f,e,d,c,b,a} showing response[k] as digit 0/1
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE; response=8'h00; valid=0; busy=0; stage=0;
//    accumulators=0. HEXk therefore shows "0" (7'b1000000).
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, signal=1: latch challenge into c_q; set acc_k=0, stage=0; load lfsr_k=SEED^(k*16'h1111)
//    (use 16'hACE1 if the result is 0); go RUN. signal=0: stay.
//  - RUN, stage i = 0..63, per chain k in parallel:
//      w_k   = signed 6-bit lfsr_k[5:0] (range -32..31), taken before the step;
//      acc_k <= (c_q[i] ? -acc_k : acc_k) + sign_extend(w_k)   (crossing stage swaps paths);
//      lfsr_k <= {1'b0, lfsr_k[15:1]} ^ (lfsr_k[0] ? 16'hB400 : 16'h0000)   (Galois, x^16+x^14+x^13+x^11+1).
//    acc_k is 13-bit signed; |acc| <= 2048, so no overflow, and negation is always exact.
//    After stage 63, go DONE.
//  - DONE: response[k] <= (acc_k > 0) (a tie gives 0); valid=1 for this one cycle; go IDLE.
//  - Latency: start sampled at edge N -> response/valid registered at edge N+65. busy=1 from
//    edge N+1 through the edge N+64 update; busy=0 in DONE.
//  - signal while RUN/DONE is ignored. A challenge change after capture has no effect.
//    Holding signal=1 restarts on the cycle after DONE.
//  - Reset mid-RUN aborts with no valid pulse and clears response to 8'h00.
//  - Same challenge + same SEED always yields the same response.
//  - HEXk = seg7(4'b000, response[k]), purely combinational from the response register.
// STRUCTURE
//  - Shared package puf_pkg: N_STAGES, N_CHAINS, ACC_W=13, W_W=6, LFSR_POLY=16'hB400,
//    SEED_STRIDE=16'h1111, SEED_FALLBACK=16'hACE1, and the 16-entry active-low seg7 table:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex, 7-bit).
//  - One sub-module seg7_decoder: 4-bit in, 7-bit active-low out, combinational, instantiated 8x.
//  - Chains are generate-loop replicas inside arbiter_puf; no further sub-modules.
// TESTING
//  1. Reset: hold rst 2 cycles -> response=8'h00, valid=0, busy=0, every HEXk=7'b1000000.
//  2. Start with challenge=64'h19f6cf91b090ac77 -> valid exactly 65 edges after start, busy high
//     for 64 cycles, response bit-exact against the golden C/Python model of BEHAVIOUR.
//     Repeat the same challenge -> identical byte.
//  3. Start with challenge=64'h0 and then 64'hFFFFFFFFFFFFFFFF -> both match the golden model;
//     HEXk shows 7'b1111001 where response[k]=1 and 7'b1000000 where it is 0.
//  4. Pulse signal and change challenge during RUN (stage 10) -> no restart, result equals the
//     originally captured challenge, exactly one valid pulse.
//  5. Assert rst at stage 30 -> next edge IDLE, response=8'h00, no valid; a new start takes a full
//     65 cycles.
//  6. Drive seg7_decoder with 0..F -> outputs match the package table exactly.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared constants and helpers for the arbiter PUF: widths, LFSR polynomial,
// per-chain seed derivation and the active-low 7-segment table.
package puf_pkg;
    localparam int N_STAGES = 64;
    localparam int N_CHAINS = 8;
    localparam int ACC_W    = 13;
    localparam int W_W      = 6;

    localparam logic [15:0] LFSR_POLY     = 16'hB400;
    localparam logic [15:0] SEED_STRIDE   = 16'h1111;
    localparam logic [15:0] SEED_FALLBACK = 16'hACE1;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is the leftmost element
    localparam logic [15:0][6:0] SEG7_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A zero LFSR state would lock up, so it falls back to the fixed seed
    function automatic logic [15:0] chain_seed(input logic [15:0] seed, input int unsigned k);
        logic [31:0] m;
        logic [15:0] s;
        m = 32'(k) * 32'(SEED_STRIDE);
        s = seed ^ m[15:0];
        return (s == 16'h0000) ? SEED_FALLBACK : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module seg7_decoder
    import puf_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);
    assign o_seg = SEG7_TAB[i_val];
endmodule

// File: rtl/arbiter_puf.sv
// Arbiter PUF model: N_CHAINS switch chains walk a captured challenge one
// stage per clock, then each chain's path-delay difference sign becomes a response bit.
module arbiter_puf
    import puf_pkg::*;
#(
    parameter int          N_STAGES = puf_pkg::N_STAGES,
    parameter int          N_CHAINS = puf_pkg::N_CHAINS,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                signal,
    input  logic [N_STAGES-1:0] challenge,
    output logic [N_CHAINS-1:0] response,
    output logic                valid,
    output logic                busy,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);
    localparam int SW = $clog2(N_STAGES);

    state_t                r_state;
    state_t                w_next;
    logic [SW-1:0]         r_stage;
    logic [N_STAGES-1:0]   r_c_q;
    logic [N_CHAINS-1:0]   r_resp;
    logic                  r_valid;
    logic [N_CHAINS-1:0]   w_pos;
    logic                  w_start;
    logic                  w_last;
    logic                  w_cross;

    assign w_start = (r_state == S_IDLE) && signal;
    assign w_last  = (r_stage == SW'(N_STAGES - 1));
    assign w_cross = r_c_q[r_stage];

    always_ff @(posedge CLOCK_50) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (signal) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_stage <= '0;
            r_c_q   <= '0;
            r_resp  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_c_q   <= challenge;
                r_stage <= '0;
            end else if (r_state == S_RUN) begin
                r_stage <= r_stage + 1'b1;
            end
            if (r_state == S_DONE) begin
                r_resp  <= w_pos;
                r_valid <= 1'b1;
            end
        end
    end

    // One accumulator + mismatch LFSR per chain; a crossing stage swaps the
    // two racing paths, which negates the running delay difference.
    for (genvar k = 0; k < N_CHAINS; k++) begin : g_chain
        logic signed [ACC_W-1:0] r_acc;
        logic        [15:0]      r_lfsr;
        logic signed [ACC_W-1:0] w_w;
        logic signed [ACC_W-1:0] w_sw;

        assign w_w  = {{(ACC_W-W_W){r_lfsr[W_W-1]}}, r_lfsr[W_W-1:0]};
        assign w_sw = w_cross ? -r_acc : r_acc;

        always_ff @(posedge CLOCK_50) begin
            if (rst) begin
                r_acc  <= '0;
                r_lfsr <= '0;
            end else if (w_start) begin
                r_acc  <= '0;
                r_lfsr <= chain_seed(SEED, k);
            end else if (r_state == S_RUN) begin
                r_acc  <= w_sw + w_w;
                r_lfsr <= lfsr_step(r_lfsr);
            end
        end

        assign w_pos[k] = (r_acc > 0);
    end

    logic [7:0][6:0] w_hex;
    for (genvar k = 0; k < 8; k++) begin : g_hex
        seg7_decoder u_seg (
            .i_val ({3'b000, r_resp[k]}),
            .o_seg (w_hex[k])
        );
    end

    assign response = r_resp;
    assign valid    = r_valid;
    assign busy     = (r_state == S_RUN);
    assign HEX0     = w_hex[0];
    assign HEX1     = w_hex[1];
    assign HEX2     = w_hex[2];
    assign HEX3     = w_hex[3];
    assign HEX4     = w_hex[4];
    assign HEX5     = w_hex[5];
    assign HEX6     = w_hex[6];
    assign HEX7     = w_hex[7];
endmodule

// File: tb/tb_arbiter_puf.sv
// Self-checking bench for arbiter_puf against an integer-arithmetic reference model.
module tb_arbiter_puf;
    logic        CLOCK_50 = 1'b0;
    logic        rst;
    logic        signal;
    logic [63:0] challenge;
    logic [7:0]  response;
    logic        valid;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [6:0]  hx [8];
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    arbiter_puf dut (
        .CLOCK_50 (CLOCK_50), .rst (rst), .signal (signal), .challenge (challenge),
        .response (response), .valid (valid), .busy (busy),
        .HEX0 (HEX0), .HEX1 (HEX1), .HEX2 (HEX2), .HEX3 (HEX3),
        .HEX4 (HEX4), .HEX5 (HEX5), .HEX6 (HEX6), .HEX7 (HEX7)
    );

    seg7_decoder u_dec (.i_val (dec_in), .o_seg (dec_out));

    assign hx[0] = HEX0; assign hx[1] = HEX1; assign hx[2] = HEX2; assign hx[3] = HEX3;
    assign hx[4] = HEX4; assign hx[5] = HEX5; assign hx[6] = HEX6; assign hx[7] = HEX7;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed integer walk of every chain's delay difference across the challenge
    function automatic logic [7:0] ref_resp(input logic [63:0] ch);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int lf, acc, w;
            lf = 'hACE1 ^ ((k * 'h1111) & 'hFFFF);
            if (lf == 0) lf = 'hACE1;
            acc = 0;
            for (int i = 0; i < 64; i++) begin
                w = lf & 63;
                if (w > 31) w = w - 64;
                acc = (ch[i] ? -acc : acc) + w;
                lf = (lf >> 1) ^ (((lf & 1) != 0) ? 'hB400 : 0);
            end
            r[k] = (acc > 0);
        end
        return r;
    endfunction

    task automatic chk_hex(input string tag, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_hex%0d", tag, k), 64'(hx[k]), r[k] ? 64'h79 : 64'h40);
    endtask

    // Start at a negedge, then sample every negedge; c counts edges after the start edge
    task automatic run_one(input logic [63:0] ch, input int glitch,
                           output logic [7:0] resp, output int lat, output int bcnt, output int vcnt);
        @(negedge CLOCK_50);
        challenge = ch;
        signal = 1'b1;
        @(negedge CLOCK_50);
        signal = 1'b0;
        lat = -1; bcnt = 0; vcnt = 0; resp = '0;
        for (int c = 0; c < 75; c++) begin
            if (c > 0) @(negedge CLOCK_50);
            if (busy) bcnt++;
            if (valid) begin
                vcnt++;
                if (lat < 0) begin lat = c; resp = response; end
            end
            if (c == glitch) begin signal = 1'b1; challenge = ~ch; end
            else if (c == glitch + 1) signal = 1'b0;
        end
    endtask

    task automatic verify(input string tag, input logic [63:0] ch, input int glitch,
                          output logic [7:0] resp);
        int lat, bcnt, vcnt;
        run_one(ch, glitch, resp, lat, bcnt, vcnt);
        chk({tag, "_lat"}, 64'(lat), 64'd65);
        chk({tag, "_busy"}, 64'(bcnt), 64'd64);
        chk({tag, "_vcnt"}, 64'(vcnt), 64'd1);
        chk({tag, "_resp"}, 64'(resp), 64'(ref_resp(ch)));
        chk_hex(tag, response);
    endtask

    logic [7:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial begin
        logic [7:0]  r1, r2;
        logic [63:0] ch;
        int          vseen, vpos0, vpos1;

        rst = 1'b1; signal = 1'b0; challenge = '0; dec_in = '0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_resp", 64'(response), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk_hex("rst", 8'h00);
        rst = 1'b0;

        verify("golden", 64'h19f6cf91b090ac77, -1, r1);
        verify("golden2", 64'h19f6cf91b090ac77, -1, r2);
        chk("repeat_same", 64'(r2), 64'(r1));
        verify("zeros", 64'h0, -1, r1);
        verify("ones", 64'hFFFFFFFFFFFFFFFF, -1, r1);

        ch = {$urandom, $urandom};
        verify("glitch", ch, 10, r1);

        for (int t = 0; t < 6; t++) begin
            ch = {$urandom, $urandom};
            verify($sformatf("rnd%0d", t), ch, -1, r1);
        end

        // Reset during RUN: aborted run must not produce a pulse
        @(negedge CLOCK_50);
        challenge = {$urandom, $urandom};
        signal = 1'b1;
        @(negedge CLOCK_50);
        signal = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        chk("midrst_resp", 64'(response), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        vseen = 0;
        for (int c = 0; c < 45; c++) begin
            if (valid) vseen++;
            @(negedge CLOCK_50);
        end
        chk("midrst_novalid", 64'(vseen), 64'd0);
        verify("after_rst", 64'h0123456789abcdef, -1, r1);

        // Held start restarts on the cycle after DONE
        @(negedge CLOCK_50);
        challenge = 64'hdeadbeefcafef00d;
        signal = 1'b1;
        vpos0 = -1; vpos1 = -1;
        for (int c = 0; c < 140; c++) begin
            @(negedge CLOCK_50);
            if (valid) begin
                if (vpos0 < 0) vpos0 = c;
                else if (vpos1 < 0) vpos1 = c;
            end
        end
        signal = 1'b0;
        chk("hold_first", 64'(vpos0), 64'd65);
        chk("hold_period", 64'(vpos1 - vpos0), 64'd66);
        chk("hold_resp", 64'(response), 64'(ref_resp(64'hdeadbeefcafef00d)));
        repeat (70) @(negedge CLOCK_50);

        for (int v = 0; v < 16; v++) begin
            dec_in = 4'(v);
            #1;
            chk($sformatf("seg7_%0h", v), 64'(dec_out), 64'(tbl[v]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
